// File: rtl/backend_pwrseq_ctrl.sv
// Receiver backend power-up/reconfiguration sequencer: VCO -> stage-1 -> stage-2 release.
// Define BACKEND_GAIN_CHECK_EN to reject gainA2 codes above 5 with an o_cfg_err pulse.
module backend_pwrseq_ctrl #(
  parameter int unsigned VCO_WAIT   = 16,
  parameter int unsigned STAGE_WAIT = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_resetb,
  input  logic       i_cfg_valid,
  input  logic [4:0] i_cfg_data,
  output logic       o_cfg_ack,
`ifdef BACKEND_GAIN_CHECK_EN
  output logic       o_cfg_err,
`endif
  output logic [1:0] o_gainA1,
  output logic [2:0] o_gainA2,
  output logic       o_resetbvco,
  output logic       o_resetb1,
  output logic       o_resetb2,
  output logic       o_ready,
  output logic       o_busy
);

  localparam int unsigned VcoEff = (VCO_WAIT == 0) ? 1 : VCO_WAIT;
  localparam int unsigned StgEff = (STAGE_WAIT == 0) ? 1 : STAGE_WAIT;
  localparam logic [CNT_W-1:0] VcoLoad = CNT_W'(VcoEff - 1);
  localparam logic [CNT_W-1:0] StgLoad = CNT_W'(StgEff - 1);

  typedef enum logic [3:0] {
    StIdle, StLoad, StVcoW, StS1W, StS2W, StRun, StTd2, StTd1, StGset
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]       r_shadow;
  logic [1:0]       r_gain_a1;
  logic [2:0]       r_gain_a2;
  logic             r_ack, r_rstb_vco, r_rstb1, r_rstb2, r_ready, r_busy;
  logic             w_req, w_bad, w_accept, w_cnt_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = i_cfg_valid && ((r_state == StIdle) || (r_state == StRun));
`ifdef BACKEND_GAIN_CHECK_EN
    w_bad       = (i_cfg_data[2:0] > 3'd5);
`else
    w_bad       = 1'b0;
`endif
    w_accept    = w_req && !w_bad;
    w_cnt_zero  = (r_cnt == '0);
    case (r_state)
      StIdle: if (w_accept) w_state_nxt = StLoad;
      StLoad: begin
        w_state_nxt = StVcoW;
        w_cnt_nxt   = VcoLoad;
      end
      StVcoW: begin
        if (w_cnt_zero) begin
          w_state_nxt = StS1W;
          w_cnt_nxt   = StgLoad;
        end else w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      StS1W: begin
        if (w_cnt_zero) begin
          w_state_nxt = StS2W;
          w_cnt_nxt   = StgLoad;
        end else w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      StS2W: begin
        if (w_cnt_zero) begin
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
        end else w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      StRun: begin
        if (w_accept) begin
          w_state_nxt = StTd2;
          w_cnt_nxt   = StgLoad;
        end
      end
      StTd2: begin
        if (w_cnt_zero) begin
          w_state_nxt = StTd1;
          w_cnt_nxt   = '0;
        end else w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      StTd1: begin
        w_state_nxt = StGset;
        w_cnt_nxt   = StgLoad;
      end
      StGset: begin
        // Gains settle with stage-1 held in reset, then re-enter the normal release path.
        if (w_cnt_zero) begin
          w_state_nxt = StS1W;
          w_cnt_nxt   = StgLoad;
        end else w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_ack      <= 1'b0;
      r_gain_a1  <= '0;
      r_gain_a2  <= '0;
      r_rstb_vco <= 1'b0;
      r_rstb1    <= 1'b0;
      r_rstb2    <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_accept;
      if (w_accept) r_shadow <= i_cfg_data;
      // Both load points sit where stage-1 is already held in reset.
      if ((r_state == StLoad) || (r_state == StTd1)) begin
        r_gain_a1 <= r_shadow[4:3];
        r_gain_a2 <= r_shadow[2:0];
      end
      r_rstb_vco <= !(w_state_nxt inside {StIdle, StLoad});
      r_rstb1    <= (w_state_nxt inside {StS1W, StS2W, StRun, StTd2});
      r_rstb2    <= (w_state_nxt inside {StS2W, StRun});
      r_ready    <= (w_state_nxt == StRun);
      r_busy     <= !(w_state_nxt inside {StIdle, StRun});
    end
  end

`ifdef BACKEND_GAIN_CHECK_EN
  logic r_err;

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) r_err <= 1'b0;
    else           r_err <= w_req && w_bad;
  end

  assign o_cfg_err = r_err;
`endif

  assign o_cfg_ack   = r_ack;
  assign o_gainA1    = r_gain_a1;
  assign o_gainA2    = r_gain_a2;
  assign o_resetbvco = r_rstb_vco;
  assign o_resetb1   = r_rstb1;
  assign o_resetb2   = r_rstb2;
  assign o_ready     = r_ready;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_backend_pwrseq_ctrl.sv
// Self-checking bench for backend_pwrseq_ctrl: timeline reference model plus invariant monitor.
module tb_backend_pwrseq_ctrl;

  localparam int V = 16;
  localparam int S = 8;

  logic       i_clk, i_resetb, i_cfg_valid;
  logic [4:0] i_cfg_data;
  logic       o_cfg_ack, o_resetbvco, o_resetb1, o_resetb2, o_ready, o_busy;
  logic [1:0] o_gainA1;
  logic [2:0] o_gainA2;
`ifdef BACKEND_GAIN_CHECK_EN
  logic       o_cfg_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_edge   = 0;

  // Model: mode 0 = idle, 1 = cold start begun at m_t, 2 = reconfig begun at m_t.
  int         m_mode = 0;
  int         m_t    = 0;
  logic [4:0] m_old  = '0;
  logic [4:0] m_new  = '0;
  logic       e_vco = 0, e_b1 = 0, e_b2 = 0, e_rdy = 0, e_busy = 0, e_ack = 0, e_err = 0;
  logic [4:0] e_gain = '0;
  logic       p_b1   = 0;
  logic [4:0] p_gain = '0;

  backend_pwrseq_ctrl #(
    .VCO_WAIT  (V),
    .STAGE_WAIT(S),
    .CNT_W     (8)
  ) dut (
    .i_clk      (i_clk),
    .i_resetb   (i_resetb),
    .i_cfg_valid(i_cfg_valid),
    .i_cfg_data (i_cfg_data),
    .o_cfg_ack  (o_cfg_ack),
`ifdef BACKEND_GAIN_CHECK_EN
    .o_cfg_err  (o_cfg_err),
`endif
    .o_gainA1   (o_gainA1),
    .o_gainA2   (o_gainA2),
    .o_resetbvco(o_resetbvco),
    .o_resetb1  (o_resetb1),
    .o_resetb2  (o_resetb2),
    .o_ready    (o_ready),
    .o_busy     (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n_edge);
    end
  endtask

  // Expected outputs after edge n_edge, from event times relative to the start edge.
  task automatic model_eval();
    int d;
    d      = n_edge - m_t;
    e_vco  = 0;
    e_b1   = 0;
    e_b2   = 0;
    e_rdy  = 0;
    e_busy = 0;
    e_gain = '0;
    if (m_mode == 1) begin
      e_vco  = (d >= 1);
      e_b1   = (d >= 1 + V);
      e_b2   = (d >= 1 + V + S);
      e_rdy  = (d >= 1 + V + 2 * S);
      e_busy = !e_rdy;
      e_gain = (d >= 1) ? m_new : m_old;
    end else if (m_mode == 2) begin
      e_vco  = 1;
      e_b1   = (d < S) || (d >= 2 * S + 1);
      e_b2   = (d >= 3 * S + 1);
      e_rdy  = (d >= 4 * S + 1);
      e_busy = !e_rdy;
      e_gain = (d >= S + 1) ? m_new : m_old;
    end
  endtask

  task automatic check_outputs();
    check_val("ack", o_cfg_ack, e_ack);
`ifdef BACKEND_GAIN_CHECK_EN
    check_val("err", o_cfg_err, e_err);
`endif
    check_val("resetbvco", o_resetbvco, e_vco);
    check_val("resetb1", o_resetb1, e_b1);
    check_val("resetb2", o_resetb2, e_b2);
    check_val("ready", o_ready, e_rdy);
    check_val("busy", o_busy, e_busy);
    check_val("gains", {o_gainA1, o_gainA2}, e_gain);
    if (o_resetb2) check_val("inv_b2_needs_b1", o_resetb1, 1);
    if (o_resetb1) check_val("inv_b1_needs_vco", o_resetbvco, 1);
    if (o_ready) check_val("inv_ready_needs_all", {o_resetbvco, o_resetb1, o_resetb2}, 3'b111);
    if (p_b1 && o_resetb1) check_val("inv_gain_stable", {o_gainA1, o_gainA2}, p_gain);
    p_b1   = o_resetb1;
    p_gain = {o_gainA1, o_gainA2};
  endtask

  task automatic step(input logic v, input logic [4:0] d);
    logic elig, bad;
    i_cfg_valid = v;
    i_cfg_data  = d;
    @(posedge i_clk);
    n_edge++;
    elig = v && i_resetb && ((m_mode == 0) || e_rdy);
`ifdef BACKEND_GAIN_CHECK_EN
    bad = (d[2:0] > 3'd5);
`else
    bad = 1'b0;
`endif
    e_ack = elig && !bad;
    e_err = elig && bad;
    if (!i_resetb) begin
      m_mode = 0;
      m_old  = '0;
      m_new  = '0;
    end else if (e_ack) begin
      m_old  = (m_mode == 0) ? 5'd0 : m_new;
      m_mode = (m_mode == 0) ? 1 : 2;
      m_new  = d;
      m_t    = n_edge;
    end
    model_eval();
    #1;
    i_cfg_valid = 1'b0;
    @(negedge i_clk);
    check_outputs();
  endtask

  // Drop reset between edges, check the immediate clear, hold for some edges, release.
  task automatic async_reset(input int hold);
    #2;
    i_resetb = 1'b0;
    #1;
    m_mode = 0;
    m_old  = '0;
    m_new  = '0;
    e_ack  = 0;
    e_err  = 0;
    model_eval();
    check_outputs();
    repeat (hold) step(1'b0, 5'd0);
    i_resetb = 1'b1;
  endtask

  initial begin
    i_resetb    = 1'b1;
    i_cfg_valid = 1'b0;
    i_cfg_data  = '0;
    async_reset(3);
    repeat (2) step(1'b0, 5'd0);

    // Cold start with an ignored request at E0+5.
    step(1'b1, 5'b10_011);
    repeat (4) step(1'b0, 5'd0);
    step(1'b1, 5'b01_110);
    repeat (35) step(1'b0, 5'd0);
    check_val("cold_ready", o_ready, 1);
    check_val("cold_gains", {o_gainA1, o_gainA2}, 5'b10_011);

    // Reconfiguration from RUN.
    step(1'b1, 5'b01_101);
    repeat (40) step(1'b0, 5'd0);
    check_val("reconf_gains", {o_gainA1, o_gainA2}, 5'b01_101);

    step(1'b1, 5'b10_011);
    repeat (40) step(1'b0, 5'd0);
    step(1'b1, 5'b10_111);
    repeat (40) step(1'b0, 5'd0);
`ifdef BACKEND_GAIN_CHECK_EN
    check_val("badgain_kept", {o_gainA1, o_gainA2}, 5'b10_011);
`else
    check_val("gain7_applied", {o_gainA1, o_gainA2}, 5'b10_111);
`endif
    check_val("badgain_ready", o_ready, 1);

    // Async reset in the middle of a cold start, then a clean cold start.
    async_reset(2);
    step(1'b1, 5'b00_010);
    repeat (20) step(1'b0, 5'd0);
    async_reset(2);
    repeat (2) step(1'b0, 5'd0);
    step(1'b1, 5'b11_001);
    repeat (40) step(1'b0, 5'd0);
    check_val("post_reset_gains", {o_gainA1, o_gainA2}, 5'b11_001);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset(2);
      step(($urandom_range(0, 15) == 0), 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
